// File: rtl/apb_to_reg_pkg.sv
// Shared types and sizing helpers for the APB4 -> register-bus bridge.
package apb_to_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } apb_to_reg_state_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned align_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb4_to_reg_cut.sv
// APB4 slave to register-bus master with a registered request path, byte strobes,
// alignment check and an optional response timeout.
module apb4_to_reg_cut
    import apb_to_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                    reg_write_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    output logic                    reg_valid_o,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_ready_i,
    input  logic                    reg_error_i
);

    localparam int unsigned           STRB_WIDTH = strb_width(DATA_WIDTH);
    localparam int unsigned           ALIGN_LSB  = align_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_LSB) - 1);

    apb_to_reg_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    timeout_hit;
    logic                    access;
    logic                    aligned;
    logic                    resp_active;

    assign access  = psel_i & penable_i;
    assign aligned = (paddr_i & ALIGN_MASK) == '0;

    // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        addr_d  = paddr_i;
                        write_d = pwrite_i;
                        wdata_d = pwdata_i;
                        wstrb_d = pwrite_i ? pstrb_i : '0;
                        state_d = REQ;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                // A handshake in the timeout cycle still completes the access normally.
                if (reg_ready_i) begin
                    rdata_d = write_q ? '0 : reg_rdata_i;
                    err_d   = reg_error_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    if (TIMEOUT_CYCLES != 0) begin : g_timeout
        localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

        logic [CNT_W-1:0] count_q, count_d;

        // Counts stalled REQ cycles; cleared whenever the bridge is not waiting.
        always_comb begin
            count_d = '0;
            if ((state_q == REQ) && !reg_ready_i) begin
                count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign timeout_hit = (state_q == REQ) && (count_q == CNT_LAST);
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    assign resp_active = (state_q == RESP);

    assign reg_valid_o = (state_q == REQ);
    assign reg_addr_o  = addr_q;
    assign reg_write_o = write_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;

    assign pready_o  = resp_active;
    assign pslverr_o = resp_active & err_q;
    assign prdata_o  = resp_active ? rdata_q : '0;

endmodule
